// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the hazard/forwarding controller
package hazard_pkg;
   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN,
      LDSTALL,
      FLUSH
   } hz_state_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             reg_write;
      logic             mem_read;
   } shadow_slot_t;

   // A load sitting in EX cannot be forwarded yet; the reader must wait a cycle.
   function automatic logic load_hit(shadow_slot_t s, logic [REG_W-1:0] rs, logic use_rs);
      return use_rs && (rs != '0) && s.valid && s.reg_write && s.mem_read && (s.rd == rs);
   endfunction
endpackage

// File: rtl/fwd_sel_calc.sv
// rtl/fwd_sel_calc.sv - forwarding select for one EX operand
module fwd_sel_calc
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] rs_i,
   input  logic             use_i,
   input  shadow_slot_t     ex_slot_i,
   input  shadow_slot_t     mem_slot_i,
   output fwd_sel_t         sel_o
);

   // The nearer producer wins; x0 and unread sources never forward.
   always_comb begin
      sel_o = FWD_REG;
      if (use_i && rs_i != '0) begin
         if (ex_slot_i.valid && ex_slot_i.reg_write && !ex_slot_i.mem_read
             && ex_slot_i.rd == rs_i) begin
            sel_o = FWD_MEM;
         end else if (mem_slot_i.valid && mem_slot_i.reg_write && mem_slot_i.rd == rs_i) begin
            sel_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - load-use stall, mispredict flush and forwarding control
module hazard_fwd_ctrl
   import hazard_pkg::*;
#(
   parameter int XLEN_REGS = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 id_valid,
   input  logic [XLEN_REGS-1:0] id_rs1,
   input  logic [XLEN_REGS-1:0] id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic [XLEN_REGS-1:0] id_rd,
   input  logic                 id_reg_write,
   input  logic                 id_mem_read,
   input  logic                 ex_mispredict,
   input  logic                 dmem_busy,
   output logic [1:0]           fwd_sel_a,
   output logic [1:0]           fwd_sel_b,
   output logic                 stall_pc_ifid,
   output logic                 bubble_idex,
   output logic                 flush_ifid,
   output logic                 freeze_all
);

   hz_state_t    state_q, state_d;
   shadow_slot_t ex_q, ex_d;
   shadow_slot_t mem_q, wb_q;
   fwd_sel_t     sel_a_calc, sel_b_calc;
   fwd_sel_t     fwd_sel_a_q, fwd_sel_a_d;
   fwd_sel_t     fwd_sel_b_q, fwd_sel_b_d;
   logic         load_use;

   fwd_sel_calc u_fwd_a (
      .rs_i       (id_rs1),
      .use_i      (id_uses_rs1),
      .ex_slot_i  (ex_q),
      .mem_slot_i (mem_q),
      .sel_o      (sel_a_calc)
   );

   fwd_sel_calc u_fwd_b (
      .rs_i       (id_rs2),
      .use_i      (id_uses_rs2),
      .ex_slot_i  (ex_q),
      .mem_slot_i (mem_q),
      .sel_o      (sel_b_calc)
   );

   assign load_use   = id_valid && (load_hit(ex_q, id_rs1, id_uses_rs1)
                                 || load_hit(ex_q, id_rs2, id_uses_rs2));
   assign freeze_all = dmem_busy;
   assign fwd_sel_a  = fwd_sel_a_q;
   assign fwd_sel_b  = fwd_sel_b_q;

   // Strobes fire in the cycle the hazard is seen; the state records what the
   // pipeline just did so a completed stall is never re-issued for the same load.
   always_comb begin
      state_d       = state_q;
      stall_pc_ifid = 1'b0;
      bubble_idex   = 1'b0;
      flush_ifid    = 1'b0;
      if (!dmem_busy) begin
         state_d = RUN;
         if (ex_mispredict) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            state_d     = FLUSH;
         end else if (load_use && state_q != LDSTALL) begin
            stall_pc_ifid = 1'b1;
            bubble_idex   = 1'b1;
            state_d       = LDSTALL;
         end
      end
   end

   always_comb begin
      ex_d        = '0;
      fwd_sel_a_d = FWD_REG;
      fwd_sel_b_d = FWD_REG;
      if (!bubble_idex && id_valid && !flush_ifid) begin
         ex_d.valid     = 1'b1;
         ex_d.rd        = id_rd;
         ex_d.reg_write = id_reg_write;
         ex_d.mem_read  = id_mem_read;
         fwd_sel_a_d    = sel_a_calc;
         fwd_sel_b_d    = sel_b_calc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         fwd_sel_a_q <= FWD_REG;
         fwd_sel_b_q <= FWD_REG;
      end else if (!dmem_busy) begin
         state_q     <= state_d;
         ex_q        <= ex_d;
         mem_q       <= ex_q;
         wb_q        <= mem_q;
         fwd_sel_a_q <= fwd_sel_a_d;
         fwd_sel_b_q <= fwd_sel_b_d;
      end
   end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - scoreboard bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
   logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
   logic       ex_mispredict = 1'b0, dmem_busy = 1'b0;
   logic [1:0] fwd_sel_a, fwd_sel_b;
   logic       stall_pc_ifid, bubble_idex, flush_ifid, freeze_all;

   hazard_fwd_ctrl #(.XLEN_REGS(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_uses_rs1   (id_uses_rs1),
      .id_uses_rs2   (id_uses_rs2),
      .id_rd         (id_rd),
      .id_reg_write  (id_reg_write),
      .id_mem_read   (id_mem_read),
      .ex_mispredict (ex_mispredict),
      .dmem_busy     (dmem_busy),
      .fwd_sel_a     (fwd_sel_a),
      .fwd_sel_b     (fwd_sel_b),
      .stall_pc_ifid (stall_pc_ifid),
      .bubble_idex   (bubble_idex),
      .flush_ifid    (flush_ifid),
      .freeze_all    (freeze_all)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       v;
      bit [4:0] rd, rs1, rs2;
      bit       u1, u2, rw, mr;
   } ins_t;

   typedef struct {
      bit [1:0] sa, sb;
      bit       stall, bubble, flush, freeze;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   // Reference: the last two instructions that entered EX (0 = now in EX/MEM, 1 = in MEM/WB).
   ins_t infl[$];
   bit [1:0] m_sa, m_sb;
   bit       m_prev_stall;

   function automatic ins_t mk(int rd, int rs1, int rs2, bit rw, bit mr, bit u1, bit u2);
      ins_t i;
      i.v = 1'b1; i.rd = rd[4:0]; i.rs1 = rs1[4:0]; i.rs2 = rs2[4:0];
      i.rw = rw; i.mr = mr; i.u1 = u1; i.u2 = u2;
      return i;
   endfunction

   function automatic ins_t empty_ins();
      ins_t i;
      i = mk(0, 0, 0, 0, 0, 0, 0);
      i.v = 1'b0;
      return i;
   endfunction

   function automatic bit [1:0] ref_sel(bit [4:0] rs, bit u);
      if (!u || rs == 0) return 2'd0;
      if (infl[0].v && infl[0].rw && !infl[0].mr && infl[0].rd == rs) return 2'd2;
      if (infl[1].v && infl[1].rw && infl[1].rd == rs) return 2'd1;
      return 2'd0;
   endfunction

   function automatic bit ld_hit(bit [4:0] rs, bit u);
      return u && rs != 0 && infl[0].v && infl[0].rw && infl[0].mr && infl[0].rd == rs;
   endfunction

   task automatic model_reset();
      infl.delete();
      infl.push_back(empty_ins());
      infl.push_back(empty_ins());
      m_sa = 0; m_sb = 0; m_prev_stall = 0;
   endtask

   task automatic drive(input ins_t i, input bit mis, input bit busy);
      id_valid = i.v; id_rd = i.rd; id_rs1 = i.rs1; id_rs2 = i.rs2;
      id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
      id_reg_write = i.rw; id_mem_read = i.mr;
      ex_mispredict = mis; dmem_busy = busy;
   endtask

   task automatic step(input ins_t i, input bit mis, input bit busy, output bit held);
      exp_t e;
      bit   lu;
      drive(i, mis, busy);
      e.sa = m_sa; e.sb = m_sb; e.freeze = busy;
      e.stall = 0; e.bubble = 0; e.flush = 0;
      held = busy;
      if (!busy) begin
         lu = i.v && (ld_hit(i.rs1, i.u1) || ld_hit(i.rs2, i.u2)) && !m_prev_stall;
         e.flush = mis;
         e.stall = !mis && lu;
         e.bubble = e.flush || e.stall;
         if (e.bubble || !i.v) begin
            m_sa = 0; m_sb = 0;
         end else begin
            m_sa = ref_sel(i.rs1, i.u1);
            m_sb = ref_sel(i.rs2, i.u2);
         end
         infl.push_front(e.bubble ? empty_ins() : i);
         void'(infl.pop_back());
         m_prev_stall = e.stall;
         held = e.stall;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input ins_t i, input bit mis, input int nbusy);
      bit h;
      for (int k = 0; k < nbusy; k++) step(i, 1'b0, 1'b1, h);
      step(i, mis, 1'b0, h);
      for (int k = 0; k < 4 && h; k++) step(i, 1'b0, 1'b0, h);
   endtask

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (fwd_sel_a !== e.sa || fwd_sel_b !== e.sb || stall_pc_ifid !== e.stall
             || bubble_idex !== e.bubble || flush_ifid !== e.flush || freeze_all !== e.freeze) begin
            bad++;
            $display("FAIL cycle t=%0t got sa=%0d sb=%0d st=%0b bu=%0b fl=%0b fr=%0b want sa=%0d sb=%0d st=%0b bu=%0b fl=%0b fr=%0b",
                     $time, fwd_sel_a, fwd_sel_b, stall_pc_ifid, bubble_idex, flush_ifid, freeze_all,
                     e.sa, e.sb, e.stall, e.bubble, e.flush, e.freeze);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      exp_t rst_e;
      ins_t nop, cur;
      bit   h;
      rst_e = '{sa: 2'd0, sb: 2'd0, stall: 1'b0, bubble: 1'b0, flush: 1'b0, freeze: 1'b0};
      nop = mk(0, 0, 0, 1, 0, 1, 0);
      model_reset();
      exp_q.push_back(rst_e);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // dependent ALU op in the next slot
      run(mk(5, 1, 2, 1, 0, 1, 1), 0, 0);
      run(mk(6, 5, 3, 1, 0, 1, 1), 0, 0);
      run(nop, 0, 0); run(nop, 0, 0);
      // distance-two forward, then nearer producer wins
      run(mk(5, 1, 2, 1, 0, 1, 1), 0, 0);
      run(nop, 0, 0);
      run(mk(7, 4, 5, 1, 0, 1, 1), 0, 0);
      run(mk(5, 1, 2, 1, 0, 1, 1), 0, 0);
      run(mk(5, 9, 0, 1, 0, 1, 0), 0, 0);
      run(mk(7, 4, 5, 1, 0, 1, 1), 0, 0);
      run(nop, 0, 0); run(nop, 0, 0);
      // load-use
      run(mk(8, 1, 0, 1, 1, 1, 0), 0, 0);
      run(mk(9, 8, 8, 1, 0, 1, 1), 0, 0);
      run(nop, 0, 0); run(nop, 0, 0);
      // mispredict squashes the x6 writer
      run(mk(6, 1, 2, 1, 0, 1, 1), 1, 0);
      run(mk(7, 6, 6, 1, 0, 1, 1), 0, 0);
      run(nop, 0, 0); run(nop, 0, 0);
      // x0 never forwards
      run(mk(0, 1, 2, 1, 0, 1, 1), 0, 0);
      run(mk(3, 0, 0, 1, 0, 1, 1), 0, 0);
      run(mk(0, 1, 2, 1, 1, 1, 1), 0, 0);
      run(mk(3, 0, 0, 1, 0, 1, 1), 0, 0);
      run(nop, 0, 0);
      // memory freeze during a load-use stall
      run(mk(8, 1, 0, 1, 1, 1, 0), 0, 0);
      run(mk(9, 8, 8, 1, 0, 1, 1), 0, 3);
      run(nop, 0, 2);
      run(nop, 0, 0); run(nop, 0, 0);

      // asynchronous reset during a load-use stall
      run(mk(8, 1, 0, 1, 1, 1, 0), 0, 0);
      drive(mk(9, 8, 8, 1, 0, 1, 1), 0, 0);
      #1 chk("stall_before_reset", stall_pc_ifid, 1);
      rst_n = 1'b0;
      #1 chk("stall_async_reset", stall_pc_ifid, 0);
      chk("bubble_async_reset", bubble_idex, 0);
      chk("sel_a_async_reset", fwd_sel_a, 0);
      model_reset();
      exp_q.push_back(rst_e);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run(nop, 0, 0);

      // random mix over a small register set
      h = 0;
      cur = nop;
      for (int n = 0; n < 400; n++) begin
         bit mis, busy;
         if (!h) begin
            cur = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 1), 1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
            cur.mr = cur.rw && ($urandom_range(0, 2) == 0);
            cur.v = ($urandom_range(0, 7) != 0);
         end
         mis = ($urandom_range(0, 9) == 0);
         busy = ($urandom_range(0, 6) == 0);
         step(cur, mis, busy, h);
      end

      drive(empty_ins(), 0, 0);
      @(negedge clk);
      #1 chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
